// File: rtl/iss_pkg.sv
// Shared types for the ISS step controller: FSM states, tohost queue entry, exit bit.
package iss_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } iss_state_e;

  // Hart field sized for the largest supported NHART (8).
  localparam int HART_W_MAX = 3;
  localparam int EXIT_BIT   = 0;

  typedef struct packed {
    logic [HART_W_MAX-1:0] hart;
    logic [31:0]           data;
  } th_entry_t;

  localparam int TH_ENTRY_W = $bits(th_entry_t);

endpackage

// File: rtl/iss_tohost_fifo.sv
// Tohost drain queue: power-of-two depth, wrap-bit pointers, registered 1-cycle fill latency.
module iss_tohost_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW:0]                 wptr, rptr;
  logic                        do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/iss_step_ctrl.sv
// Round-robin ISS hart stepper with one outstanding instruction and a tohost drain queue.
// Optional trace port enabled by defining ISS_TRACE_EN.
module iss_step_ctrl
  import iss_pkg::*;
#(
  parameter int  NHART     = 2,
  parameter int  XLEN      = 64,
  parameter int  THQ_DEPTH = 4,
  localparam int HW        = (NHART > 1) ? $clog2(NHART) : 1
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             run,
  input  logic             halt_req,
  input  logic [XLEN-1:0]  entry_pc,
  input  logic [31:0]      max_inst,
  output logic             ex_valid,
  output logic [HW-1:0]    ex_hart,
  output logic [XLEN-1:0]  ex_pc,
  input  logic             ex_ready,
  input  logic             ex_done,
  input  logic [XLEN-1:0]  ex_next_pc,
  input  logic             ex_tohost_we,
  input  logic [31:0]      ex_tohost,
  output logic             th_valid,
  input  logic             th_ready,
  output logic [31:0]      th_data,
  output logic [HW-1:0]    th_hart,
  output logic             busy,
  output logic             done,
  output logic [63:0]      retired,
  output logic [NHART-1:0] hart_halted
`ifdef ISS_TRACE_EN
  ,
  output logic             tr_valid,
  output logic [HW-1:0]    tr_hart,
  output logic [XLEN-1:0]  tr_pc,
  output logic [XLEN-1:0]  tr_next_pc
`endif
);

  iss_state_e              state, state_nx;
  logic [NHART-1:0][XLEN-1:0] pc;
  logic [HW-1:0]           cur, cur_nx;
  logic [63:0]             retired_nx;
  logic [NHART-1:0]        halted_nx;
  logic                    halt_seen;
  logic                    hs, accept, exit_wr, stop;
  logic                    q_full, q_empty, q_push, q_pop;
  th_entry_t               q_din, q_dout;
  logic [HART_W_MAX-1:0]   unused_q_hart;

  assign hs         = ex_valid && ex_ready;
  assign accept     = (state == ST_WAIT) && ex_done;
  assign exit_wr    = ex_tohost_we && ex_tohost[EXIT_BIT];
  assign retired_nx = retired + 64'd1;

  always_comb begin
    halted_nx = hart_halted;
    if (exit_wr) halted_nx[cur] = 1'b1;
  end

  // Next non-halted hart after cur; stays on cur if everything is halted.
  always_comb begin
    logic          found;
    int            idx;
    logic [HW-1:0] sel;
    cur_nx = cur;
    found  = 1'b0;
    for (int k = 1; k <= NHART; k++) begin
      idx = (int'(cur) + k) % NHART;
      sel = idx[HW-1:0];
      if (!found && !halted_nx[sel]) begin
        cur_nx = sel;
        found  = 1'b1;
      end
    end
  end

  assign stop = (&halted_nx)
             || ((max_inst != 32'd0) && (retired_nx == {32'd0, max_inst}))
             || halt_seen || halt_req;

  // FSM: state register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (run) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        if (hs)            state_nx = ST_WAIT;
        else if (halt_req) state_nx = ST_DONE;
      end
      ST_WAIT:  if (accept) state_nx = stop ? ST_DONE : ST_ISSUE;
      ST_DONE:  if (!run) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // FSM: outputs. Issue is held back while the queue has no room for a possible push.
  always_comb begin
    ex_valid = (state == ST_ISSUE) && !q_full;
    busy     = (state == ST_ISSUE) || (state == ST_WAIT);
    done     = (state == ST_DONE);
  end

  assign ex_hart = cur;
  assign ex_pc   = pc[cur];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pc          <= '0;
      cur         <= '0;
      retired     <= '0;
      hart_halted <= '0;
      halt_seen   <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (run) begin
        for (int h = 0; h < NHART; h++) pc[h] <= entry_pc;
        cur         <= '0;
        retired     <= '0;
        hart_halted <= '0;
        halt_seen   <= 1'b0;
      end
    end else begin
      if (busy && halt_req) halt_seen <= 1'b1;
      if (accept) begin
        pc[cur]     <= ex_next_pc;
        retired     <= retired_nx;
        hart_halted <= halted_nx;
        cur         <= cur_nx;
      end
    end
  end

  assign q_push = accept && ex_tohost_we;
  assign q_pop  = th_valid && th_ready;
  assign q_din  = '{hart: HART_W_MAX'(cur), data: ex_tohost};

  iss_tohost_fifo #(
    .WIDTH (TH_ENTRY_W),
    .DEPTH (THQ_DEPTH)
  ) u_thq (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .dout  (q_dout),
    .empty (q_empty),
    .full  (q_full)
  );

  assign th_valid      = !q_empty;
  assign th_data       = q_dout.data;
  assign unused_q_hart = q_dout.hart;
  assign th_hart       = q_dout.hart[HW-1:0];

`ifdef ISS_TRACE_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tr_valid   <= 1'b0;
      tr_hart    <= '0;
      tr_pc      <= '0;
      tr_next_pc <= '0;
    end else begin
      tr_valid <= accept;
      if (accept) begin
        tr_hart    <= cur;
        tr_pc      <= pc[cur];
        tr_next_pc <= ex_next_pc;
      end
    end
  end
`endif

endmodule
